arbitrated_output_stage: RTL and testbench

//  Registered output stage directly downstream of the arbitrated FIFO bank's onehot grant mux.

---
 rtl/arbitrated_output_stage.sv | 139 +++++++++++++
 tb/tb_arbitrated_output_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/arbitrated_output_stage.sv
// Registered output stage behind the arbitrated FIFO bank's grant mux.
// Encodes the onehot grant into a source tag and buffers words in a 2-entry skid buffer.
module arbitrated_output_stage #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int CNTWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] in_gnt,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_rdy,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAGWIDTH-1:0]  out_tag,
    output logic [CNTWIDTH-1:0]  acc_cnt,
    output logic                 gnt_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      head_data_q, head_data_d;
    logic [TAGWIDTH-1:0]   head_tag_q, head_tag_d;
    logic [WIDTH-1:0]      skid_data_q, skid_data_d;
    logic [TAGWIDTH-1:0]   skid_tag_q, skid_tag_d;
    logic [CNTWIDTH-1:0]   acc_cnt_q, acc_cnt_d;
    logic                  gnt_err_q, gnt_err_d;

    logic                  gnt_any;
    logic                  gnt_onehot;
    logic                  accept;
    logic                  bad_gnt;
    logic                  drain;
    logic [TAGWIDTH-1:0]   in_tag;

    // Ready depends only on state and reset, never on out_rdy
    assign in_rdy   = ~rst & (state_q != FULL);
    assign out_vld  = (state_q != EMPTY);
    assign out_data = head_data_q;
    assign out_tag  = head_tag_q;
    assign acc_cnt  = acc_cnt_q;
    assign gnt_err  = gnt_err_q;

    // Classify the grant and encode its set bit into a binary tag
    always_comb begin
        gnt_any    = |in_gnt;
        gnt_onehot = gnt_any &
                     ((in_gnt & (in_gnt - NUM_FIFOS'(1))) == '0);
        accept     = in_rdy & gnt_onehot;
        bad_gnt    = in_rdy & gnt_any & ~gnt_onehot;
        drain      = out_vld & out_rdy;
        in_tag     = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (in_gnt[i]) begin
                in_tag = in_tag | TAGWIDTH'(i);
            end
        end
    end

    // Next-state logic for the skid buffer, counter and error flag
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_tag_d  = head_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        acc_cnt_d   = acc_cnt_q + CNTWIDTH'(accept);
        gnt_err_d   = gnt_err_q | bad_gnt;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_data_d = in_data;
                    head_tag_d  = in_tag;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    head_data_d = in_data;
                    head_tag_d  = in_tag;
                end else if (accept) begin
                    skid_data_d = in_data;
                    skid_tag_d  = in_tag;
                    state_d     = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    head_data_d = skid_data_q;
                    head_tag_d  = skid_tag_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register with synchronous reset; buffered words are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
            acc_cnt_q   <= '0;
            gnt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_tag_q  <= head_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
            acc_cnt_q   <= acc_cnt_d;
            gnt_err_q   <= gnt_err_d;
        end
    end

`ifdef FORMAL
    a_full_not_rdy: assert property (@(posedge clk)
        state_q == FULL |-> !in_rdy);
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        out_vld && !out_rdy |=> out_vld && $stable(out_data) && $stable(out_tag));
    a_rst_empty: assert property (@(posedge clk)
        rst |=> !out_vld);
    m_no_gnt: assume property (@(posedge clk)
        !in_rdy |-> in_gnt == '0);
`endif

endmodule

// File: tb/tb_arbitrated_output_stage.sv
// Bench for arbitrated_output_stage: directed cases then random traffic
// against a queue-based model of the buffer.
module tb_arbitrated_output_stage;

    localparam int NF = 4;
    localparam int W  = 8;
    localparam int TW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] in_gnt = '0;
    logic [W-1:0]  in_data = '0;
    logic          in_rdy;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] acc_cnt;
    logic          gnt_err;

    arbitrated_output_stage #(
        .NUM_FIFOS(NF), .WIDTH(W), .TAGWIDTH(TW), .CNTWIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_gnt(in_gnt), .in_data(in_data),
        .in_rdy(in_rdy), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_data(out_data), .out_tag(out_tag), .acc_cnt(acc_cnt),
        .gnt_err(gnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int data;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;
    bit   m_err = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit m_rdy();
        return !rst && q.size() < 2;
    endfunction

    // Applies this edge's inputs to the model: pop first, then push
    task automatic model_update();
        bit rdy;
        int ones;
        int idx;
        ent_t e;
        rdy = m_rdy();
        ones = $countones(in_gnt);
        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_err = 0;
        end else begin
            if (q.size() > 0 && out_rdy) void'(q.pop_front());
            if (rdy && ones == 1) begin
                idx = 0;
                for (int i = 0; i < NF; i++) if (in_gnt[i]) idx = i;
                e.tag = idx;
                e.data = int'(in_data);
                q.push_back(e);
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            if (rdy && ones > 1) m_err = 1;
        end
    endtask

    task automatic check_state();
        chk("out_vld", 32'(out_vld), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        end
        chk("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
        chk("gnt_err", 32'(gnt_err), 32'(m_err));
    endtask

    task automatic cyc(input logic r, input logic [NF-1:0] g,
                       input logic [W-1:0] d, input logic ordy);
        @(negedge clk);
        check_state();
        rst = r;
        in_gnt = g;
        in_data = d;
        out_rdy = ordy;
        #1 chk("in_rdy", 32'(in_rdy), 32'(m_rdy()));
        @(posedge clk);
        model_update();
    endtask

    initial begin
        logic          r;
        logic [NF-1:0] g;
        logic          o;
        int            sel;

        // Reset
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        #1;
        chk("rst_vld", 32'(out_vld), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_tag", 32'(out_tag), 0);
        chk("rst_cnt", 32'(acc_cnt), 0);
        chk("rst_err", 32'(gnt_err), 0);
        cyc(0, 0, 0, 0);

        // Streaming
        cyc(0, 4'b0010, 8'hA5, 1);
        #1;
        chk("t2_data0", 32'(out_data), 32'hA5);
        chk("t2_tag0", 32'(out_tag), 1);
        cyc(0, 4'b1000, 8'h3C, 1);
        #1;
        chk("t2_data1", 32'(out_data), 32'h3C);
        chk("t2_tag1", 32'(out_tag), 3);
        chk("t2_cnt", 32'(acc_cnt), 2);
        cyc(0, 0, 0, 1);

        // Backpressure
        cyc(0, 4'b0001, 8'h11, 0);
        cyc(0, 4'b0100, 8'h22, 0);
        #1;
        chk("t3_full_rdy", 32'(in_rdy), 0);
        chk("t3_hold", 32'(out_data), 32'h11);
        cyc(0, 0, 0, 0);
        #1 chk("t3_hold2", 32'(out_data), 32'h11);
        cyc(0, 0, 0, 1);
        #1;
        chk("t3_second", 32'(out_data), 32'h22);
        chk("t3_rdy", 32'(in_rdy), 1);
        cyc(0, 0, 0, 1);

        // Accept and drain together in ONE
        cyc(0, 4'b0001, 8'h11, 0);
        cyc(0, 4'b0010, 8'h33, 1);
        #1;
        chk("t4_head", 32'(out_data), 32'h33);
        chk("t4_vld", 32'(out_vld), 1);
        chk("t4_rdy", 32'(in_rdy), 1);
        cyc(0, 0, 0, 1);

        // Bad grant
        cyc(0, 4'b0110, 8'h77, 1);
        #1;
        chk("t5_err", 32'(gnt_err), 1);
        chk("t5_vld", 32'(out_vld), 0);
        chk("t5_cnt", 32'(acc_cnt), 6);
        cyc(0, 0, 0, 1);
        #1 chk("t5_sticky", 32'(gnt_err), 1);

        // Counter wrap and reset while full
        cyc(1, 0, 0, 1);
        #1 chk("t6_err_clr", 32'(gnt_err), 0);
        for (int i = 0; i < 17; i++) cyc(0, 4'b0100, 8'(i), 1);
        #1 chk("t6_wrap", 32'(acc_cnt), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 4'b0001, 8'hAA, 0);
        cyc(0, 4'b0010, 8'hBB, 0);
        #1 chk("t6_full", 32'(in_rdy), 0);
        cyc(1, 0, 0, 0);
        #1;
        chk("t6_rst_vld", 32'(out_vld), 0);
        chk("t6_rst_cnt", 32'(acc_cnt), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(99) == 0);
            o = ($urandom_range(3) != 0);
            sel = $urandom_range(99);
            if (sel < 65) g = NF'(1) << $urandom_range(NF - 1);
            else if (sel < 85) g = '0;
            else g = NF'($urandom);
            if (!(!r && q.size() < 2) && $urandom_range(19) != 0) g = '0;
            cyc(r, g, W'($urandom), o);
        end
        cyc(0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
